linreg_engine: RTL
==================

Name: linreg_engine

Overview:
- Streaming least-squares line-fit engine. Accepts N signed (x, y) samples over a valid/ready handshake and accumulates Σx, Σy, Σx², Σxy.
- Computes slope b1 and intercept b0 as signed fixed-point values using two sequential restoring divisions.
- Parametrised successor of the fixed 20-bit coefficient datapath. Contains its own FSM, so no external controller is required.

Parameters:
- W, 20, sample width and output coefficient width (signed two's complement).
- NMAX, 64, maximum sample count per fit.
- FRAC, 8, fractional bits of b1/b0 outputs (Q format W-FRAC.FRAC).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a fit; sampled only in IDLE
- n_in  in  CW=$clog2(NMAX+1)  sample count, latched on start
- s_valid  in  1  sample valid
- s_ready  out  1  engine accepts sample
- s_x  in  W  signed x sample
- s_y  in  W  signed y sample
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when b1/b0 are valid
- b1  out  W  signed slope, FRAC fraction bits
- b0  out  W  signed intercept, FRAC fraction bits
- degen  out  1  denominator zero or n_in<2 on the last fit
- ovf  out  1  a quotient did not fit in W bits on the last fit

Behaviour:
- Reset (async) values: all outputs 0, state IDLE, accumulators and counter 0.
- Widths:
  - Sx and Sy are W+CW bits.
  - Sxx and Sxy are 2W+CW bits.
  - num and den are 2W+2CW+1 bits.
  - QW = 2W+2CW+FRAC+1 is the divider quotient width.
- IDLE:
  - On start: latch n_in, clear accumulators and counter.
  - If n_in<2: go to DONE with degen=1, b1=0, b0=0.
  - Otherwise go to ACCUM.
  - start in any other state is ignored.
- ACCUM:
  - s_ready=1. Each cycle with s_valid&s_ready, add the sample into all four sums and increment the counter.
  - On the handshake that brings the counter to n: go to CALC. s_ready drops in the following cycle.
  - s_ready=0 in all other states; s_valid is ignored when s_ready=0.
- CALC (1 cycle):
  - num = n·Sxy − Sx·Sy; den = n·Sxx − Sx².
  - If den==0: set degen=1, set the full-precision slope to 0, go to B0PREP.
  - Otherwise go to DIV1.
- DIV1 (QW cycles):
  - Restoring division on magnitudes, |num|<<FRAC ÷ |den|, one quotient bit per cycle, MSB first.
  - Sign = sign(num) XOR sign(den); result truncates toward zero.
  - The full QW-bit signed quotient q1 is retained.
- B0PREP (1 cycle): t = (Sy<<FRAC) − q1·Sx, using the full-precision q1, never the clipped b1.
- DIV2 (QW cycles): q0 = t ÷ n, signed, truncated toward zero, same divider.
- DONE (1 cycle):
  - Register b1 and b0 from q1 and q0, clipped per the optional feature.
  - ovf = either quotient is outside the W-bit signed range.
  - done=1; return to IDLE.
- Latency: done asserts 2·QW+3 cycles after the final sample handshake. With den==0, DIV1 is skipped.
- b1, b0, degen and ovf hold until the next DONE. degen and ovf are cleared when the next fit starts.
- Reset mid-operation: immediate abort to IDLE with all outputs 0. No done pulse.
- Accumulators never overflow for n≤NMAX by construction of the widths. Behaviour for n_in>NMAX is undefined.

Optional Feature:
- Macro LINREG_SAT_EN.
- Defined: an out-of-range q1/q0 saturates to +2^(W-1)−1 or −2^(W-1).
- Undefined: b1/b0 take the low W bits of the quotient (wrap).
- ovf is asserted identically in both builds.

Test Plan (W=20, FRAC=8, NMAX=64):
- n=3, samples (1,3),(2,5),(3,7) -> b1=512, b0=256, degen=0, ovf=0; done exactly 2·QW+3 cycles after the 3rd handshake.
- n=4, samples (0,10),(1,8),(2,6),(3,4) -> b1=0xFFE00 (−512), b0=2560.
- n=3, samples (0,0),(1,1),(2,1) -> b1=128, b0=42 (truncation toward zero).
- n=3, samples (5,1),(5,2),(5,3) -> degen=1, b1=0, b0=512. Separately: n_in=1 -> done in the cycle after start, degen=1, b1=b0=0.
- n=2, samples (0,0),(1,500000) -> ovf=1, b0=0. b1=0x7FFFF with LINREG_SAT_EN; b1=73728 without it.
- Backpressure and reset:
  - s_valid held high across a fit: exactly n samples consumed, and s_ready=0 from CALC through DONE.
  - start pulsed while busy: ignored.
  - rst asserted during DIV1: outputs immediately 0, busy=0, no done pulse.
  - A subsequent fit completes correctly.

Source files
------------

// File: rtl/linreg_engine.sv
// Streaming least-squares line fit: b1/b0 in Q(W-FRAC).FRAC from N (x,y) samples; LINREG_SAT_EN selects saturating clip (default: wrap).
// Latency 2*QW+3 cycles from final sample handshake to done; s_ready is high only while accumulating.
module linreg_engine #(
  parameter int W    = 20,
  parameter int NMAX = 64,
  parameter int FRAC = 8,
  localparam int CW  = $clog2(NMAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] n_in,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_x,
  input  logic [W-1:0]  s_y,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  b1,
  output logic [W-1:0]  b0,
  output logic          degen,
  output logic          ovf
);

  localparam int SW = W + CW;
  localparam int PW = 2 * W + CW;
  localparam int DW = 2 * W + 2 * CW + 1;
  localparam int QW = DW + FRAC;
  localparam int KW = $clog2(QW);
  localparam logic [CW-1:0] N_TWO = CW'(2);

  typedef enum logic [2:0] {IDLE, ACCUM, CALC, DIV1, B0PREP, DIV2, DONE} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]        n_q, n_d, cnt_q, cnt_d;
  logic signed [SW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic signed [PW-1:0] sxx_q, sxx_d, sxy_q, sxy_d;
  logic [QW-1:0]        dvd_q, dvd_d;
  logic [DW-1:0]        dvs_q, dvs_d, rem_q, rem_d;
  logic                 neg_q, neg_d;
  logic [KW-1:0]        dcnt_q, dcnt_d;
  logic signed [QW-1:0] q1_q, q1_d;
  logic [W-1:0]         b1_q, b1_d, b0_q, b0_d;
  logic                 degen_q, degen_d, ovf_q, ovf_d;

  logic                 fire, short_n, acc_last, div_last, den_zero;
  logic [CW-1:0]        cnt_inc;
  logic signed [PW-1:0] x_p, y_p;
  logic signed [DW-1:0] n_e, sx_e, sy_e, sxx_e, sxy_e, num, den;
  logic [DW-1:0]        num_mag, den_mag, rem_nx;
  logic [DW:0]          rem_sh;
  logic                 q_bit;
  logic [QW-1:0]        q_mag, t_mag;
  logic signed [QW-1:0] q_sgn, sy_t, sx_t, t_val;
  logic                 fit1, fit0;
  logic [W-1:0]         b1_clip, b0_clip;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = short_n ? DONE : ACCUM;
      ACCUM:   if (acc_last) state_d = CALC;
      CALC:    state_d = den_zero ? B0PREP : DIV1;
      DIV1:    if (div_last) state_d = B0PREP;
      B0PREP:  state_d = DIV2;
      DIV2:    if (div_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM outputs ----------------
  always_comb begin
    s_ready = (state_q == ACCUM);
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
  end

  // ---------------- datapath arithmetic ----------------
  always_comb begin
    fire     = s_valid & s_ready;
    short_n  = (n_in < N_TWO);
    cnt_inc  = cnt_q + CW'(1);
    acc_last = fire && (cnt_inc == n_q);
    div_last = (dcnt_q == KW'(QW - 1));

    x_p = {{(PW - W){s_x[W-1]}}, s_x};
    y_p = {{(PW - W){s_y[W-1]}}, s_y};

    n_e   = {{(DW - CW){1'b0}}, n_q};
    sx_e  = {{(DW - SW){sx_q[SW-1]}}, sx_q};
    sy_e  = {{(DW - SW){sy_q[SW-1]}}, sy_q};
    sxx_e = {{(DW - PW){sxx_q[PW-1]}}, sxx_q};
    sxy_e = {{(DW - PW){sxy_q[PW-1]}}, sxy_q};
    num   = n_e * sxy_e - sx_e * sy_e;
    den   = n_e * sxx_e - sx_e * sx_e;
    num_mag  = num[DW-1] ? -num : num;
    den_mag  = den[DW-1] ? -den : den;
    den_zero = (den == '0);

    // One restoring step: the dividend register shifts out MSB-first and collects quotient bits.
    rem_sh = {rem_q, dvd_q[QW-1]};
    q_bit  = (rem_sh >= {1'b0, dvs_q});
    rem_nx = q_bit ? (rem_sh[DW-1:0] - dvs_q) : rem_sh[DW-1:0];
    q_mag  = {dvd_q[QW-2:0], q_bit};
    q_sgn  = neg_q ? -q_mag : q_mag;

    // Intercept numerator uses the unclipped slope; arithmetic is modulo 2^QW.
    sy_t  = {{(QW - SW){sy_q[SW-1]}}, sy_q};
    sx_t  = {{(QW - SW){sx_q[SW-1]}}, sx_q};
    t_val = (sy_t <<< FRAC) - q1_q * sx_t;
    t_mag = t_val[QW-1] ? -t_val : t_val;

    fit1 = (&q1_q[QW-1:W-1])  | ~(|q1_q[QW-1:W-1]);
    fit0 = (&q_sgn[QW-1:W-1]) | ~(|q_sgn[QW-1:W-1]);
`ifdef LINREG_SAT_EN
    if (fit1)          b1_clip = q1_q[W-1:0];
    else if (q1_q[QW-1]) b1_clip = {1'b1, {(W - 1){1'b0}}};
    else               b1_clip = {1'b0, {(W - 1){1'b1}}};
    if (fit0)          b0_clip = q_sgn[W-1:0];
    else if (q_sgn[QW-1]) b0_clip = {1'b1, {(W - 1){1'b0}}};
    else               b0_clip = {1'b0, {(W - 1){1'b1}}};
`else
    b1_clip = q1_q[W-1:0];
    b0_clip = q_sgn[W-1:0];
`endif
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    n_d     = n_q;
    cnt_d   = cnt_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sxx_d   = sxx_q;
    sxy_d   = sxy_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    dcnt_d  = dcnt_q;
    q1_d    = q1_q;
    b1_d    = b1_q;
    b0_d    = b0_q;
    degen_d = degen_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n_in;
          cnt_d   = '0;
          sx_d    = '0;
          sy_d    = '0;
          sxx_d   = '0;
          sxy_d   = '0;
          ovf_d   = 1'b0;
          degen_d = short_n;
          if (short_n) begin
            b1_d = '0;
            b0_d = '0;
          end
        end
      end
      ACCUM: begin
        if (fire) begin
          cnt_d = cnt_inc;
          sx_d  = sx_q + {{CW{s_x[W-1]}}, s_x};
          sy_d  = sy_q + {{CW{s_y[W-1]}}, s_y};
          sxx_d = sxx_q + x_p * x_p;
          sxy_d = sxy_q + x_p * y_p;
        end
      end
      CALC: begin
        if (den_zero) begin
          degen_d = 1'b1;
          q1_d    = '0;
        end else begin
          dvd_d  = {num_mag, {FRAC{1'b0}}};
          dvs_d  = den_mag;
          neg_d  = num[DW-1] ^ den[DW-1];
          rem_d  = '0;
          dcnt_d = '0;
        end
      end
      DIV1: begin
        dvd_d  = q_mag;
        rem_d  = rem_nx;
        dcnt_d = dcnt_q + KW'(1);
        if (div_last) q1_d = q_sgn;
      end
      B0PREP: begin
        dvd_d  = t_mag;
        dvs_d  = {{(DW - CW){1'b0}}, n_q};
        neg_d  = t_val[QW-1];
        rem_d  = '0;
        dcnt_d = '0;
      end
      DIV2: begin
        dvd_d  = q_mag;
        rem_d  = rem_nx;
        dcnt_d = dcnt_q + KW'(1);
        if (div_last) begin
          b1_d  = b1_clip;
          b0_d  = b0_clip;
          ovf_d = ~(fit1 & fit0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q     <= '0;
      cnt_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      sxx_q   <= '0;
      sxy_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      dcnt_q  <= '0;
      q1_q    <= '0;
      b1_q    <= '0;
      b0_q    <= '0;
      degen_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sxx_q   <= sxx_d;
      sxy_q   <= sxy_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      dcnt_q  <= dcnt_d;
      q1_q    <= q1_d;
      b1_q    <= b1_d;
      b0_q    <= b0_d;
      degen_q <= degen_d;
      ovf_q   <= ovf_d;
    end
  end

  assign b1    = b1_q;
  assign b0    = b0_q;
  assign degen = degen_q;
  assign ovf   = ovf_q;

endmodule
